// File: rtl/rally_ctrl_pkg.sv
// rally_ctrl_pkg: shared state encoding, key bit indices and score helper for the rally game.
package rally_ctrl_pkg;
    typedef enum logic [2:0] {SERVE, TO_P2, TO_P1, POINT, OVER} state_t;
    localparam int KEY_P1    = 3;
    localparam int KEY_RST   = 2;
    localparam int KEY_PAUSE = 1;
    localparam int KEY_P2    = 0;
    localparam int CW        = 27;
    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s >= lim) ? lim : s + 4'd1;
    endfunction
endpackage

// File: rtl/rally_step_timer.sv
// rally_step_timer: free-running step counter that pulses wrap on its last count.
module rally_step_timer
    import rally_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] period,
    output logic          wrap
);
    logic [CW-1:0] cnt;
    assign wrap = en && (cnt == period - CW'(1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + CW'(1);
endmodule

// File: rtl/rally_ctrl.sv
// rally_ctrl: table-tennis sequencer driving serve, ball travel, judging, scoring and game-over.
module rally_ctrl
    import rally_ctrl_pkg::*;
#(
    parameter int LEDS      = 8,
    parameter int STEP_INIT = 12_500_000,
    parameter int STEP_DEC  = 1_000_000,
    parameter int STEP_MIN  = 4_000_000,
    parameter int HOLD      = 50_000_000,
    parameter int WIN_SCORE = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      key_flag,
    output logic [LEDS-1:0] led,
    output logic [3:0]      score1,
    output logic [3:0]      score2,
    output logic            server,
    output logic            paused,
    output logic            game_over,
    output logic [1:0]      winner
);
    localparam int PW = $clog2(LEDS);
    localparam logic [PW-1:0] END1 = PW'(LEDS - 1);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);
    state_t state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [CW-1:0] period_q, period_d, dec_period;
    logic [3:0] s1_d, s2_d;
    logic [1:0] winner_d;
    logic [LEDS-1:0] led_d;
    logic server_d, paused_d;
    logic rst_k, p1, p2, pz, moving, active, rx_hit, rx_end, srv_hit, p1_scores, point, clr, en, wrap;
    assign rst_k      = key_flag[KEY_RST];
    assign p1         = key_flag[KEY_P1];
    assign p2         = key_flag[KEY_P2];
    assign pz         = key_flag[KEY_PAUSE];
    assign moving     = (state_q == TO_P1) || (state_q == TO_P2);
    assign paused_d   = moving && !rst_k && (paused ^ pz);
    assign active     = moving && !paused_d;
    assign p1_scores  = (state_q == TO_P2);
    assign rx_hit     = p1_scores ? p2 : p1;
    assign rx_end     = p1_scores ? (pos_q == '0) : (pos_q == END1);
    assign srv_hit    = server ? p2 : p1;
    assign point      = active && (rx_hit ? !rx_end : (wrap && rx_end));
    assign dec_period = (period_q >= CW'(STEP_MIN + STEP_DEC)) ? period_q - CW'(STEP_DEC) : CW'(STEP_MIN);
    // A receiver hit wins over a coinciding wrap because clear has priority in the timer.
    assign clr        = rst_k || (state_q == SERVE && srv_hit) || (active && rx_hit);
    assign en         = (state_q == POINT) || active;
    rally_step_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .en     (en),
        .period ((state_q == POINT) ? CW'(HOLD) : period_q),
        .wrap   (wrap)
    );
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        period_d = period_q;
        s1_d     = score1;
        s2_d     = score2;
        server_d = server;
        winner_d = winner;
        unique case (state_q)
            SERVE: if (srv_hit) begin
                state_d  = server ? TO_P1 : TO_P2;
                period_d = CW'(STEP_INIT);
            end
            TO_P1, TO_P2: if (point) begin
                state_d  = POINT;
                s1_d     = p1_scores ? sat_inc(score1, WIN) : score1;
                s2_d     = p1_scores ? score2 : sat_inc(score2, WIN);
                server_d = p1_scores;
            end else if (active && rx_hit) begin
                state_d  = p1_scores ? TO_P1 : TO_P2;
                period_d = dec_period;
            end else if (active && wrap)
                pos_d = p1_scores ? pos_q - PW'(1) : pos_q + PW'(1);
            POINT: if (wrap) begin
                state_d  = (score1 == WIN || score2 == WIN) ? OVER : SERVE;
                winner_d = (score1 == WIN) ? 2'b01 : (score2 == WIN) ? 2'b10 : 2'b00;
                pos_d    = (score1 == WIN) ? END1 : (score2 == WIN || server) ? '0 : END1;
            end
            default: ;
        endcase
        if (rst_k) begin
            state_d  = SERVE;
            pos_d    = END1;
            period_d = CW'(STEP_INIT);
            s1_d     = '0;
            s2_d     = '0;
            server_d = 1'b0;
            winner_d = 2'b00;
        end
        led_d = (state_d == POINT) ? '1 : LEDS'(1) << pos_d;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= SERVE;
            pos_q     <= END1;
            period_q  <= CW'(STEP_INIT);
            score1    <= '0;
            score2    <= '0;
            server    <= 1'b0;
            paused    <= 1'b0;
            winner    <= 2'b00;
            game_over <= 1'b0;
            led       <= LEDS'(1) << END1;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            period_q  <= period_d;
            score1    <= s1_d;
            score2    <= s2_d;
            server    <= server_d;
            paused    <= paused_d;
            winner    <= winner_d;
            game_over <= (state_d == OVER);
            led       <= led_d;
        end
endmodule

// File: tb/tb_rally_ctrl.sv
// tb_rally_ctrl: directed and random stimulus for rally_ctrl against a countdown-based game model.
module tb_rally_ctrl;
    localparam int L = 4, INIT = 8, DEC = 2, MIN = 4, HOLD = 3, WIN = 2;
    localparam logic [3:0] K_P1 = 4'b1000, K_RST = 4'b0100, K_PZ = 4'b0010, K_P2 = 4'b0001, K_0 = 4'b0000;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] key_flag = 4'b0;
    logic [L-1:0] led;
    logic [3:0] score1, score2;
    logic server, paused, game_over;
    logic [1:0] winner;
    int n_checks = 0;
    int n_errors = 0;
    // Model: mode 0 serve, 1 moving, 2 point hold, 3 over; dir -1 toward P2 end (0), +1 toward P1 end.
    int m_mode, m_pos, m_dir, m_rem, m_per, m_s1, m_s2, m_srv, m_pause, m_hold;

    rally_ctrl #(.LEDS(L), .STEP_INIT(INIT), .STEP_DEC(DEC), .STEP_MIN(MIN), .HOLD(HOLD), .WIN_SCORE(WIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_flag  (key_flag),
        .led       (led),
        .score1    (score1),
        .score2    (score2),
        .server    (server),
        .paused    (paused),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = L - 1; m_dir = -1; m_rem = 0; m_per = INIT;
        m_s1 = 0; m_s2 = 0; m_srv = 0; m_pause = 0; m_hold = 0;
    endtask

    task automatic award(input int who);
        if (who == 1) begin
            m_s1 = (m_s1 < WIN) ? m_s1 + 1 : WIN;
            m_srv = 1;
        end else begin
            m_s2 = (m_s2 < WIN) ? m_s2 + 1 : WIN;
            m_srv = 0;
        end
        m_mode = 2;
        m_hold = HOLD;
    endtask

    task automatic model(input logic [3:0] k);
        int e;
        logic rk;
        if (k[2]) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: if (m_srv == 0 ? k[3] : k[0]) begin
                m_mode = 1; m_dir = m_srv ? 1 : -1; m_per = INIT; m_rem = INIT;
            end
            1: begin
                if (k[1]) m_pause = 1 - m_pause;
                if (m_pause == 0) begin
                    rk = (m_dir < 0) ? k[0] : k[3];
                    e = (m_dir < 0) ? 0 : L - 1;
                    if (rk) begin
                        if (m_pos == e) begin
                            m_dir = -m_dir;
                            m_per = (m_per - DEC > MIN) ? m_per - DEC : MIN;
                            m_rem = m_per;
                        end else award(m_dir < 0 ? 1 : 2);
                    end else begin
                        m_rem--;
                        if (m_rem == 0) begin
                            if (m_pos == e) award(m_dir < 0 ? 1 : 2);
                            else begin
                                m_pos += m_dir;
                                m_rem = m_per;
                            end
                        end
                    end
                end
            end
            2: begin
                m_hold--;
                if (m_hold == 0) begin
                    if (m_s1 == WIN) begin m_mode = 3; m_pos = L - 1; end
                    else if (m_s2 == WIN) begin m_mode = 3; m_pos = 0; end
                    else begin m_mode = 0; m_pos = m_srv ? 0 : L - 1; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        int e_led;
        e_led = (m_mode == 2) ? (1 << L) - 1 : (1 << m_pos);
        check("led", 32'(led), 32'(e_led));
        check("score1", 32'(score1), 32'(m_s1));
        check("score2", 32'(score2), 32'(m_s2));
        check("server", 32'(server), 32'(m_srv));
        check("paused", 32'(paused), 32'(m_pause));
        check("game_over", 32'(game_over), 32'(m_mode == 3));
        check("winner", 32'(winner), 32'((m_mode == 3) ? ((m_s1 == WIN) ? 1 : 2) : 0));
    endtask

    task automatic step(input logic [3:0] k);
        key_flag = k;
        model(k);
        @(negedge clk);
        key_flag = K_0;
        compare_all();
    endtask

    initial begin
        logic [3:0] k;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        check("rst_led", 32'(led), 32'h8);
        // Serve and full traverse, then returns shortening the period down to the floor.
        step(K_P1);
        repeat (8) step(K_0);
        check("serve_step", 32'(led), 32'h4);
        repeat (16) step(K_0);
        check("p2_end", 32'(led), 32'h1);
        step(K_P2);
        repeat (6) step(K_0);
        check("ret_period6", 32'(led), 32'h2);
        repeat (12) step(K_0);
        check("p1_end", 32'(led), 32'h8);
        step(K_P1);
        repeat (4) step(K_0);
        check("ret_period4", 32'(led), 32'h4);
        repeat (8) step(K_0);
        step(K_P2);
        repeat (4) step(K_0);
        check("period_floor", 32'(led), 32'h2);
        // Miss by P2.
        step(K_RST);
        step(K_P1);
        repeat (32) step(K_0);
        check("miss_score1", 32'(score1), 32'd1);
        check("miss_hold_led", 32'(led), 32'hF);
        repeat (2) step(K_0);
        check("hold_led", 32'(led), 32'hF);
        step(K_0);
        check("new_serve_led", 32'(led), 32'h1);
        check("new_server", 32'(server), 32'd1);
        // Early press by P2 with a simultaneous P1 press.
        step(K_RST);
        step(K_P1);
        repeat (8) step(K_0);
        step(K_P1 | K_P2);
        check("early_score1", 32'(score1), 32'd1);
        check("early_score2", 32'(score2), 32'd0);
        // Pause mid-count with hits hammered while frozen.
        step(K_RST);
        step(K_P1);
        repeat (3) step(K_0);
        step(K_PZ);
        check("pause_on", 32'(paused), 32'd1);
        for (int i = 0; i < 100; i++) step(4'($urandom_range(0, 1) << 3) | 4'($urandom_range(0, 1)));
        check("pause_led", 32'(led), 32'h8);
        check("pause_score", 32'({score1, score2}), 32'h0);
        step(K_PZ);
        repeat (3) step(K_0);
        check("resume_wait", 32'(led), 32'h8);
        step(K_0);
        check("resume_step", 32'(led), 32'h4);
        // P1 always returns, P2 never does: P1 wins.
        step(K_RST);
        for (int i = 0; i < 400 && m_mode != 3; i++)
            step((m_mode == 0) ? (m_srv ? K_P2 : K_P1) :
                 (m_mode == 1 && m_dir > 0 && m_pos == L - 1) ? K_P1 : K_0);
        check("over_game_over", 32'(game_over), 32'd1);
        check("over_winner", 32'(winner), 32'd1);
        check("over_led", 32'(led), 32'h8);
        step(K_P1 | K_P2);
        check("over_ignore", 32'(led), 32'h8);
        step(K_RST);
        check("restart_scores", 32'({score1, score2}), 32'h0);
        check("restart_server", 32'(server), 32'd0);
        check("restart_over", 32'(game_over), 32'd0);
        // Random play with receivers biased toward well-timed returns.
        for (int i = 0; i < 3000; i++) begin
            k = K_0;
            if ($urandom_range(0, 5) == 0) k |= K_P1;
            if ($urandom_range(0, 5) == 0) k |= K_P2;
            if ($urandom_range(0, 29) == 0) k |= K_PZ;
            if ($urandom_range(0, 399) == 0) k |= K_RST;
            if (m_mode == 1 && m_pause == 0 && $urandom_range(0, 3) != 0) begin
                if (m_dir < 0 && m_pos == 0) k |= K_P2;
                if (m_dir > 0 && m_pos == L - 1) k |= K_P1;
            end
            step(k);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
